// File: rtl/rf_pkg.sv
// Register-file geometry, write-back payload type and the destination decode helper.
package rf_pkg;

    localparam int unsigned NREQ_DEF = 4;
    localparam int unsigned NREG     = 8;
    localparam int unsigned AW       = 3;
    localparam int unsigned DW       = 16;

    typedef struct packed {
        logic [AW-1:0] dest;
        logic [DW-1:0] data;
    } wb_req_t;

    // One-hot register select; destinations beyond the register file decode to zero.
    function automatic logic [NREG-1:0] onehot_dest(input logic [AW-1:0] dest);
        logic [NREG-1:0] oh;
        oh = '0;
        if (32'(dest) < NREG) begin
            oh[dest] = 1'b1;
        end
        return oh;
    endfunction

endpackage

// File: rtl/rf_writeback_arbiter_if.sv
// Write-back requester, issue and register-file write bundle around the arbiter.
interface rf_writeback_arbiter_if #(
    parameter int unsigned NREQ = 4
);
    import rf_pkg::*;

    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_dest;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;

    logic               issue_valid;
    logic [AW-1:0]      issue_dest;

    logic               wr0_en;
    logic [AW-1:0]      wr0_addr;
    logic [DW-1:0]      wr0_data;
    logic               wr1_en;
    logic [AW-1:0]      wr1_addr;
    logic [DW-1:0]      wr1_data;

    logic [NREG-1:0]    busy;

    // Execution units and issue logic side.
    modport master (
        output req_valid, req_dest, req_data, issue_valid, issue_dest,
        input  req_ready, wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data, busy
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_dest, req_data, issue_valid, issue_dest,
        output req_ready, wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data, busy
    );

endinterface

// File: rtl/rr_pick2.sv
// Rotating two-winner picker: first valid from ptr wins A, next valid with a different dest wins B.
module rr_pick2 #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned AW   = 3,
    parameter int unsigned PW   = 2
) (
    input  logic [NREQ-1:0]    valid,
    input  logic [NREQ*AW-1:0] dest,
    input  logic [PW-1:0]      ptr,
    output logic [NREQ-1:0]    grant,
    output logic [PW-1:0]      idx_a,
    output logic [PW-1:0]      idx_b,
    output logic               hit_a,
    output logic               hit_b
);

    logic [PW:0]   cand_w;
    logic [PW-1:0] cand;
    logic [AW-1:0] cand_dest;
    logic [AW-1:0] dest_a;

    // Walk the requesters in rotated order; a same-dest candidate after A is skipped.
    always_comb begin
        grant     = '0;
        idx_a     = '0;
        idx_b     = '0;
        hit_a     = 1'b0;
        hit_b     = 1'b0;
        dest_a    = '0;
        cand_w    = '0;
        cand      = '0;
        cand_dest = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand_w = {1'b0, ptr} + (PW+1)'(k);
            if (cand_w >= (PW+1)'(NREQ)) begin
                cand_w = cand_w - (PW+1)'(NREQ);
            end
            cand      = cand_w[PW-1:0];
            cand_dest = dest[32'(cand)*AW +: AW];
            if (valid[cand]) begin
                if (!hit_a) begin
                    hit_a       = 1'b1;
                    idx_a       = cand;
                    dest_a      = cand_dest;
                    grant[cand] = 1'b1;
                end else if (!hit_b && (cand_dest != dest_a)) begin
                    hit_b       = 1'b1;
                    idx_b       = cand;
                    grant[cand] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rf_writeback_arbiter.sv
// Shares the two register-file write ports among NREQ write-back requesters and
// tracks outstanding register writes in a busy scoreboard.
module rf_writeback_arbiter
    import rf_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF
) (
    input  logic                  Clk,
    input  logic                  Reset,
    rf_writeback_arbiter_if.slave bus
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NREQ-1:0] grant;
    logic [PW-1:0]   idx_a, idx_b;
    logic            hit_a, hit_b;
    wb_req_t         req_a, req_b;

    logic            wr0_en_q, wr0_en_d;
    logic [AW-1:0]   wr0_addr_q, wr0_addr_d;
    logic [DW-1:0]   wr0_data_q, wr0_data_d;
    logic            wr1_en_q, wr1_en_d;
    logic [AW-1:0]   wr1_addr_q, wr1_addr_d;
    logic [DW-1:0]   wr1_data_q, wr1_data_d;

    logic [NREG-1:0] busy_q, busy_d;
    logic [NREG-1:0] busy_set, busy_clr;

    // Advance past the given requester, wrapping at NREQ.
    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] idx);
        logic [PW:0] nxt;
        nxt = {1'b0, idx} + (PW+1)'(1);
        if (nxt >= (PW+1)'(NREQ)) begin
            nxt = '0;
        end
        return nxt[PW-1:0];
    endfunction

    rr_pick2 #(
        .NREQ (NREQ),
        .AW   (AW),
        .PW   (PW)
    ) u_pick (
        .valid (bus.req_valid),
        .dest  (bus.req_dest),
        .ptr   (rr_ptr_q),
        .grant (grant),
        .idx_a (idx_a),
        .idx_b (idx_b),
        .hit_a (hit_a),
        .hit_b (hit_b)
    );

    // Grants are suppressed while reset is asserted so no transfer completes in reset.
    assign bus.req_ready = Reset ? '0 : grant;

    // Extract the payloads of the two winners.
    always_comb begin
        req_a = '{dest: bus.req_dest[32'(idx_a)*AW +: AW], data: bus.req_data[32'(idx_a)*DW +: DW]};
        req_b = '{dest: bus.req_dest[32'(idx_b)*AW +: AW], data: bus.req_data[32'(idx_b)*DW +: DW]};
    end

    // Next pointer, port registers and scoreboard.
    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        wr0_en_d   = hit_a;
        wr0_addr_d = wr0_addr_q;
        wr0_data_d = wr0_data_q;
        wr1_en_d   = hit_b;
        wr1_addr_d = wr1_addr_q;
        wr1_data_d = wr1_data_q;
        busy_clr   = '0;
        busy_set   = '0;

        if (hit_b) begin
            rr_ptr_d = wrap_inc(idx_b);
        end else if (hit_a) begin
            rr_ptr_d = wrap_inc(idx_a);
        end

        if (hit_a) begin
            wr0_addr_d = req_a.dest;
            wr0_data_d = req_a.data;
            busy_clr   = busy_clr | onehot_dest(req_a.dest);
        end
        if (hit_b) begin
            wr1_addr_d = req_b.dest;
            wr1_data_d = req_b.data;
            busy_clr   = busy_clr | onehot_dest(req_b.dest);
        end

        if (bus.issue_valid) begin
            busy_set = onehot_dest(bus.issue_dest);
        end

        // A fresh issue overrides a completing write to the same register.
        busy_d = (busy_q & ~busy_clr) | busy_set;
    end

    // State registers with asynchronous reset.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rr_ptr_q   <= '0;
            wr0_en_q   <= 1'b0;
            wr0_addr_q <= '0;
            wr0_data_q <= '0;
            wr1_en_q   <= 1'b0;
            wr1_addr_q <= '0;
            wr1_data_q <= '0;
            busy_q     <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            wr0_en_q   <= wr0_en_d;
            wr0_addr_q <= wr0_addr_d;
            wr0_data_q <= wr0_data_d;
            wr1_en_q   <= wr1_en_d;
            wr1_addr_q <= wr1_addr_d;
            wr1_data_q <= wr1_data_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.wr0_en   = wr0_en_q;
    assign bus.wr0_addr = wr0_addr_q;
    assign bus.wr0_data = wr0_data_q;
    assign bus.wr1_en   = wr1_en_q;
    assign bus.wr1_addr = wr1_addr_q;
    assign bus.wr1_data = wr1_data_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Randomised and directed bench for rf_writeback_arbiter with a behavioural reference model.
module tb_rf_writeback_arbiter;
    import rf_pkg::*;

    localparam int NQ = 4;

    logic Clk = 1'b0;
    logic Reset;

    always #5 Clk = ~Clk;

    rf_writeback_arbiter_if #(.NREQ(NQ)) bus ();

    rf_writeback_arbiter #(.NREQ(NQ)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    // Requester and issue stimulus state.
    bit            rq_v [NQ];
    wb_req_t       rq   [NQ];
    bit            iss_v;
    logic [AW-1:0] iss_d;

    // Reference model state.
    int            m_ptr;
    bit [NREG-1:0] m_busy;
    bit            m_en0, m_en1;
    logic [AW-1:0] m_a0, m_a1;
    logic [DW-1:0] m_d0, m_d1;
    int            ga, gb;
    logic [NQ-1:0] exp_ready, last_ready;

    int checks = 0;
    int errors = 0;

    logic [NQ-1:0] t5_exp [3];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NQ; i++) begin
            bus.req_valid[i]          = rq_v[i];
            bus.req_dest[i*AW +: AW]  = rq[i].dest;
            bus.req_data[i*DW +: DW]  = rq[i].data;
        end
        bus.issue_valid = iss_v;
        bus.issue_dest  = iss_d;
    endtask

    task automatic set_req(input int i, input int d, input int v);
        rq_v[i]    = 1'b1;
        rq[i].dest = AW'(d);
        rq[i].data = DW'(v);
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_busy = '0;
        m_en0  = 1'b0;
        m_en1  = 1'b0;
        m_a0   = '0;
        m_a1   = '0;
        m_d0   = '0;
        m_d1   = '0;
    endtask

    // Winners from the rules: rotated order, first valid, then first later valid with a different dest.
    task automatic model_pick();
        int order[$];
        ga = -1;
        gb = -1;
        for (int k = 0; k < NQ; k++) order.push_back((m_ptr + k) % NQ);
        foreach (order[j]) begin
            int i;
            i = order[j];
            if (rq_v[i]) begin
                if (ga < 0) ga = i;
                else if (gb < 0 && rq[i].dest != rq[ga].dest) gb = i;
            end
        end
    endtask

    task automatic check_outputs();
        chk("wr0_en",   64'(bus.wr0_en),   64'(m_en0));
        chk("wr1_en",   64'(bus.wr1_en),   64'(m_en1));
        chk("wr0_addr", 64'(bus.wr0_addr), 64'(m_a0));
        chk("wr0_data", 64'(bus.wr0_data), 64'(m_d0));
        chk("wr1_addr", 64'(bus.wr1_addr), 64'(m_a1));
        chk("wr1_data", 64'(bus.wr1_data), 64'(m_d1));
        chk("busy",     64'(bus.busy),     64'(m_busy));
    endtask

    // One clock: starts and ends with the clock low.
    task automatic cycle();
        drive();
        #1;
        model_pick();
        exp_ready = '0;
        if (ga >= 0) exp_ready = exp_ready | (NQ'(1) << ga);
        if (gb >= 0) exp_ready = exp_ready | (NQ'(1) << gb);
        last_ready = bus.req_ready;
        chk("req_ready", 64'(last_ready), 64'(exp_ready));
        @(posedge Clk);
        m_en0 = (ga >= 0);
        m_en1 = (gb >= 0);
        if (ga >= 0) begin
            m_a0 = rq[ga].dest;
            m_d0 = rq[ga].data;
            if (32'(rq[ga].dest) < NREG) m_busy[rq[ga].dest] = 1'b0;
        end
        if (gb >= 0) begin
            m_a1 = rq[gb].dest;
            m_d1 = rq[gb].data;
            if (32'(rq[gb].dest) < NREG) m_busy[rq[gb].dest] = 1'b0;
        end
        if (iss_v && 32'(iss_d) < NREG) m_busy[iss_d] = 1'b1;
        if (gb >= 0)      m_ptr = (gb + 1) % NQ;
        else if (ga >= 0) m_ptr = (ga + 1) % NQ;
        if (ga >= 0) rq_v[ga] = 1'b0;
        if (gb >= 0) rq_v[gb] = 1'b0;
        #1;
        check_outputs();
        @(negedge Clk);
    endtask

    // Reset pulsed between clock edges; outputs must clear immediately.
    task automatic reset_pulse();
        Reset = 1'b1;
        #1;
        model_reset();
        chk("rst_wr0_en",    64'(bus.wr0_en),    64'(0));
        chk("rst_wr1_en",    64'(bus.wr1_en),    64'(0));
        chk("rst_busy",      64'(bus.busy),      64'(0));
        chk("rst_req_ready", 64'(bus.req_ready), 64'(0));
        #1;
        Reset = 1'b0;
    endtask

    initial begin
        t5_exp[0] = 4'b0011;
        t5_exp[1] = 4'b1100;
        t5_exp[2] = 4'b0011;
        for (int i = 0; i < NQ; i++) begin
            rq_v[i] = 1'b0;
            rq[i]   = '0;
        end
        iss_v = 1'b0;
        iss_d = '0;
        Reset = 1'b1;
        drive();
        model_reset();
        #3;
        check_outputs();
        chk("reset_ready", 64'(bus.req_ready), 64'(0));
        @(negedge Clk);
        Reset = 1'b0;

        // Single write.
        set_req(2, 5, 16'h00AB);
        cycle();
        chk("t2_ready",    64'(last_ready),   64'(4'b0100));
        chk("t2_wr0_en",   64'(bus.wr0_en),   64'(1));
        chk("t2_wr0_addr", 64'(bus.wr0_addr), 64'(5));
        chk("t2_wr0_data", 64'(bus.wr0_data), 64'(16'h00AB));
        chk("t2_wr1_en",   64'(bus.wr1_en),   64'(0));

        // Dual write.
        set_req(0, 4, 1);
        set_req(1, 6, 2);
        cycle();
        chk("t3_ready",    64'(last_ready),   64'(4'b0011));
        chk("t3_wr0_addr", 64'(bus.wr0_addr), 64'(4));
        chk("t3_wr0_data", 64'(bus.wr0_data), 64'(1));
        chk("t3_wr1_en",   64'(bus.wr1_en),   64'(1));
        chk("t3_wr1_addr", 64'(bus.wr1_addr), 64'(6));
        chk("t3_wr1_data", 64'(bus.wr1_data), 64'(2));

        // Same-dest conflict: the second requester waits one cycle.
        set_req(0, 7, 16'h0011);
        set_req(1, 7, 16'h0022);
        cycle();
        chk("t4a_ready",    64'(last_ready),   64'(4'b0001));
        chk("t4a_wr0_addr", 64'(bus.wr0_addr), 64'(7));
        chk("t4a_wr0_data", 64'(bus.wr0_data), 64'(16'h0011));
        chk("t4a_wr1_en",   64'(bus.wr1_en),   64'(0));
        cycle();
        chk("t4b_ready",    64'(last_ready),   64'(4'b0010));
        chk("t4b_wr0_en",   64'(bus.wr0_en),   64'(1));
        chk("t4b_wr0_data", 64'(bus.wr0_data), 64'(16'h0022));
        cycle();
        chk("t4c_wr0_en",   64'(bus.wr0_en),   64'(0));
        chk("t4c_wr0_hold", 64'(bus.wr0_data), 64'(16'h0022));

        // Scoreboard set, set-beats-clear, then clear.
        iss_v = 1'b1;
        iss_d = 3'd3;
        cycle();
        chk("t6a_busy3", 64'(bus.busy[3]), 64'(1));
        set_req(0, 3, 16'h0033);
        cycle();
        chk("t6b_busy3", 64'(bus.busy[3]), 64'(1));
        iss_v = 1'b0;
        set_req(0, 3, 16'h0044);
        cycle();
        chk("t6c_busy3", 64'(bus.busy[3]), 64'(0));

        // Reset in the middle of traffic.
        iss_v = 1'b1;
        iss_d = 3'd2;
        for (int i = 0; i < NQ; i++) set_req(i, i, 16'h0100 + i);
        cycle();
        iss_v = 1'b0;
        chk("t1_pre_wr0_en", 64'(bus.wr0_en),  64'(1));
        chk("t1_pre_busy2",  64'(bus.busy[2]), 64'(1));
        for (int i = 0; i < NQ; i++) rq_v[i] = 1'b1;
        drive();
        reset_pulse();

        // Fairness: all requesters held valid with distinct dests.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < NQ; i++) set_req(i, i + 4, 16'h0200 + 16 * r + i);
            cycle();
            chk("t5_ready", 64'(last_ready), 64'(t5_exp[r]));
        end

        // Randomised traffic.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < NQ; i++) begin
                if (!rq_v[i] && $urandom_range(0, 2) == 0) begin
                    set_req(i, (cyc % 400 < 200) ? $urandom_range(0, 2) : $urandom_range(0, 7),
                            $urandom_range(0, 65535));
                end
            end
            iss_v = ($urandom_range(0, 3) == 0);
            iss_d = AW'($urandom_range(0, 7));
            cycle();
            if ($urandom_range(0, 499) == 0) reset_pulse();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
